velocity_cell_ctrl: RTL and testbench
=====================================

Name: velocity_cell_ctrl

Overview:
- Sequencer and arbiter for one per-cell velocity memory: a single-port RAM with 2-cycle read latency (address in, registered data out).
- Word layout is {vz, vy, vx}; address 0 holds the cell's particle count.
- Runs one motion-update pass: streams velocities 1..N to the motion-update unit and writes the updated velocities back in order.
- Gives a host/debug reader access to the memory only while no pass is running.

Parameters:
- DATA_WIDTH, 96, velocity word width {vz,vy,vx}.
- ADDR_WIDTH, 8, memory address width.
- PARTICLE_NUM, 220, memory depth; the largest particle count is PARTICLE_NUM-1.
- RD_LATENCY, 2, memory read latency in cycles.
- MAX_OUTSTANDING, 8, maximum number of particles read but not yet written back.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  single-cycle pulse that begins a pass.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse at the end of a pass.
- vel_out  out  DATA_WIDTH  old velocity sent to the motion-update unit.
- vel_out_addr  out  ADDR_WIDTH  particle address of vel_out.
- vel_out_valid  out  1  one-cycle qualifier for vel_out; no backpressure.
- upd_in  in  DATA_WIDTH  updated velocity, returned in issue order.
- upd_valid  in  1  upd_in is valid.
- upd_ready  out  1  controller accepts upd_in this cycle.
- host_rd_req  in  1  host read request.
- host_rd_addr  in  ADDR_WIDTH  host read address.
- host_rd_gnt  out  1  host request accepted this cycle.
- host_rd_data  out  DATA_WIDTH  host read data.
- host_rd_valid  out  1  host_rd_data is valid, RD_LATENCY cycles after the grant.
- mem_address  out  ADDR_WIDTH  RAM address.
- mem_data  out  DATA_WIDTH  RAM write data.
- mem_rden  out  1  RAM read enable.
- mem_wren  out  1  RAM write enable.
- mem_q  in  DATA_WIDTH  RAM read data.

Behaviour:
- Reset: every output is 0; state is IDLE; all counters and the tag pipe are cleared.
  - Reset applies immediately, including mid-pass; mem_wren drops asynchronously.
  - A partially written pass is abandoned, not resumed.
- FSM states: IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 moves to CNT_RD. If start and host_rd_req arrive in the same cycle, start wins and host_rd_gnt stays 0.
  - host_rd_req=1 with no start drives host_rd_gnt=1 and mem_rden=1 at host_rd_addr.
- CNT_RD: read address 0, then go to CNT_WAIT.
- CNT_WAIT: wait RD_LATENCY cycles, then latch N = mem_q[ADDR_WIDTH-1:0].
  - N is clamped to PARTICLE_NUM-1.
  - N=0 goes directly to DONE; otherwise go to STREAM.
- Counters: rd_ptr (next address to read), wr_ptr (next address to write back), outstanding = issued - written. rd_ptr and wr_ptr both start at 1.
- Per-cycle port arbitration in STREAM and DRAIN:
  - A write has priority: if upd_valid and upd_ready, then mem_wren=1 at wr_ptr with upd_in; wr_ptr increments.
  - Otherwise a read is issued when rd_ptr ≤ N and outstanding < MAX_OUTSTANDING: mem_rden=1 at rd_ptr; rd_ptr increments.
- upd_ready = 1 when delivered > written, where delivered counts particles already presented on vel_out.
- vel_out_valid pulses RD_LATENCY cycles after each read issue, together with vel_out = mem_q and vel_out_addr set to the tag of that read.
- STREAM moves to DRAIN once rd_ptr > N. DRAIN moves to DONE once wr_ptr > N.
- DONE: pulse done for one cycle, clear busy, return to IDLE.
- A start pulse while busy is ignored. While busy, host_rd_gnt is 0.
- Outstanding can never exceed MAX_OUTSTANDING. A write and a read are never issued in the same cycle.

Optional Feature:
- Macro VEL_CTRL_STALL_CNT_EN.
- Defined: adds output port stall_cycles [15:0].
  - Counts STREAM cycles in which a read was blocked only by the outstanding limit.
  - Cleared on accepted start; saturates at 16'hFFFF; holds its value after done; reset value 0.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package vel_ctrl_pkg holds:
  - state enum;
  - default constants VEL_DATA_WIDTH=96, VEL_ADDR_WIDTH=8, VEL_RD_LATENCY=2;
  - count-word field position [ADDR_WIDTH-1:0].
- One sub-module, vel_rd_tag_pipe: a RD_LATENCY-deep shift register carrying {valid, is_host, addr}.
  - Its output steers mem_q to either vel_out or host_rd_data.

Test Plan:
- Reset mid-STREAM with N=5, pulled after 3 reads -> all outputs 0 within the reset cycle; a new start reruns the pass from address 1.
- Count word = 0, start -> done asserted 2+RD_LATENCY+1 cycles after start; no vel_out_valid; no mem_wren.
- N=3, upd_valid held high -> vel_out_addr 1,2,3 in order; writes to addresses 1,2,3 with matching upd_in; exactly one done; busy low after.
- N=20, MAX_OUTSTANDING=8, upd_valid held low -> exactly 8 reads issued, then stall; releasing upd_valid completes all 20; with VEL_CTRL_STALL_CNT_EN, stall_cycles is nonzero and equals the blocked-cycle count.
- start and host_rd_req in the same IDLE cycle -> host_rd_gnt=0, pass begins. Host read of address 7 in IDLE -> host_rd_valid 2 cycles later with the stored word.
- Count word = 300 with PARTICLE_NUM=220 -> N clamped to 219; last write address is 219.

Source files
------------

// File: rtl/vel_ctrl_pkg.sv
// Shared types and defaults for the velocity-memory controller.
// Optional build macro: VEL_CTRL_STALL_CNT_EN (see velocity_cell_ctrl).
package vel_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_RD,
        CNT_WAIT,
        STREAM,
        DRAIN,
        DONE
    } vel_state_t;

    localparam int unsigned VEL_DATA_WIDTH = 96;
    localparam int unsigned VEL_ADDR_WIDTH = 8;
    localparam int unsigned VEL_RD_LATENCY = 2;

    // Particle count lives in the low ADDR_WIDTH bits of the word at address 0.
    localparam int unsigned VEL_CNT_LSB = 0;

endpackage

// File: rtl/vel_rd_tag_pipe.sv
// Read tag pipeline: carries {valid, is_host, addr} alongside the RAM read
// latency so returning mem_q can be steered to the right consumer.
module vel_rd_tag_pipe
    import vel_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = VEL_ADDR_WIDTH,
    parameter int unsigned RD_LATENCY = VEL_RD_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_is_host,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    output logic                  out_is_host,
    output logic [ADDR_WIDTH-1:0] out_addr
);

    localparam int unsigned TAG_W = ADDR_WIDTH + 2;

    logic [TAG_W-1:0] stage [RD_LATENCY];

    // Shift one tag per cycle; the last stage lines up with mem_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= {in_valid, in_is_host, in_addr};
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign {out_valid, out_is_host, out_addr} = stage[RD_LATENCY-1];

endmodule

// File: rtl/velocity_cell_ctrl.sv
// Velocity memory sequencer/arbiter: runs one motion-update pass over
// particles 1..N (count at address 0) and gives host reads the port when idle.
// Optional build macro: VEL_CTRL_STALL_CNT_EN adds the stall_cycles output.
module velocity_cell_ctrl
    import vel_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = VEL_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH      = VEL_ADDR_WIDTH,
    parameter int unsigned PARTICLE_NUM    = 220,
    parameter int unsigned RD_LATENCY      = VEL_RD_LATENCY,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] vel_out,
    output logic [ADDR_WIDTH-1:0] vel_out_addr,
    output logic                  vel_out_valid,
    input  logic [DATA_WIDTH-1:0] upd_in,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic                  host_rd_req,
    input  logic [ADDR_WIDTH-1:0] host_rd_addr,
    output logic                  host_rd_gnt,
    output logic [DATA_WIDTH-1:0] host_rd_data,
    output logic                  host_rd_valid,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q
`ifdef VEL_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);

    localparam int unsigned PTR_W  = ADDR_WIDTH + 1;
    localparam int unsigned WAIT_W = $clog2(RD_LATENCY + 1);

    localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]      N_MAX     = PTR_W'(PARTICLE_NUM - 1);
    localparam logic [PTR_W-1:0]      OS_MAX    = PTR_W'(MAX_OUTSTANDING);
    localparam logic [DATA_WIDTH-1:0] CNT_LIMIT = DATA_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [WAIT_W-1:0]     WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(RD_LATENCY - 1);
    localparam logic [WAIT_W-1:0]     WAIT_END  = WAIT_W'(RD_LATENCY);

    vel_state_t state, state_nxt;

    logic                  alive;
    logic [PTR_W-1:0]      rd_ptr, wr_ptr, del_ptr, n_reg, n_latch, outstanding;
    logic [WAIT_W-1:0]     wait_cnt;
    logic                  accept_start, in_pass;
    logic                  wr_en, rd_en;
    logic                  pipe_in_valid, pipe_in_host;
    logic                  p_valid, p_is_host;
    logic [ADDR_WIDTH-1:0] p_addr;
    logic                  vel_hit, host_hit;

    assign accept_start = (state == IDLE) && start;
    assign in_pass      = (state == STREAM) || (state == DRAIN);
    assign outstanding  = rd_ptr - wr_ptr;

    // Count word: a value too large for the memory (including one that does
    // not fit the count field) saturates to the last particle address.
    always_comb begin
        n_latch = '0;
        if (mem_q > CNT_LIMIT) begin
            n_latch = N_MAX;
        end else begin
            n_latch = PTR_W'(mem_q[VEL_CNT_LSB +: ADDR_WIDTH]);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. N is registered one cycle before the zero-count
    // branch so the wide clamp compare stays off the next-state path.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start) state_nxt = CNT_RD;
            CNT_RD:   state_nxt = CNT_WAIT;
            CNT_WAIT: if (wait_cnt == WAIT_END) state_nxt = (n_reg == '0) ? DONE : STREAM;
            STREAM:   if (rd_ptr > n_reg) state_nxt = DRAIN;
            DRAIN:    if (wr_ptr > n_reg) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output and port arbitration: write-back beats a new read every cycle.
    always_comb begin
        busy          = (state == CNT_RD) || (state == CNT_WAIT) || in_pass;
        done          = (state == DONE);
        host_rd_gnt   = alive && (state == IDLE) && host_rd_req && !start;
        upd_ready     = in_pass && (del_ptr > wr_ptr);
        wr_en         = upd_ready && upd_valid;
        rd_en         = (state == STREAM) && !wr_en && (rd_ptr <= n_reg) && (outstanding < OS_MAX);
        mem_wren      = wr_en;
        mem_rden      = host_rd_gnt || (state == CNT_RD) || rd_en;
        mem_data      = '0;
        mem_address   = '0;
        pipe_in_valid = rd_en || host_rd_gnt;
        pipe_in_host  = host_rd_gnt;
        if (wr_en) begin
            mem_address = wr_ptr[ADDR_WIDTH-1:0];
            mem_data    = upd_in;
        end else if (rd_en) begin
            mem_address = rd_ptr[ADDR_WIDTH-1:0];
        end else if (host_rd_gnt) begin
            mem_address = host_rd_addr;
        end
    end

    // Pass counters and latched particle count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive    <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            del_ptr  <= '0;
            n_reg    <= '0;
            wait_cnt <= '0;
        end else begin
            alive <= 1'b1;
            if (accept_start) begin
                rd_ptr   <= PTR_ONE;
                wr_ptr   <= PTR_ONE;
                del_ptr  <= PTR_ONE;
                n_reg    <= '0;
                wait_cnt <= '0;
            end else begin
                if (state == CNT_WAIT) begin
                    wait_cnt <= wait_cnt + WAIT_ONE;
                    if (wait_cnt == WAIT_LAST) n_reg <= n_latch;
                end
                if (rd_en)   rd_ptr  <= rd_ptr + PTR_ONE;
                if (wr_en)   wr_ptr  <= wr_ptr + PTR_ONE;
                if (vel_hit) del_ptr <= del_ptr + PTR_ONE;
            end
        end
    end

    vel_rd_tag_pipe #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_tag_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (pipe_in_valid),
        .in_is_host  (pipe_in_host),
        .in_addr     (mem_address),
        .out_valid   (p_valid),
        .out_is_host (p_is_host),
        .out_addr    (p_addr)
    );

    // Steer returning read data to the motion-update unit or the host.
    always_comb begin
        vel_hit       = p_valid && !p_is_host;
        host_hit      = p_valid && p_is_host;
        vel_out_valid = vel_hit;
        vel_out       = vel_hit ? mem_q : '0;
        vel_out_addr  = vel_hit ? p_addr : '0;
        host_rd_valid = host_hit;
        host_rd_data  = host_hit ? mem_q : '0;
    end

`ifdef VEL_CTRL_STALL_CNT_EN
    logic stall_hit;

    assign stall_hit = (state == STREAM) && !wr_en && (rd_ptr <= n_reg) && (outstanding >= OS_MAX);

    // Saturating count of STREAM cycles lost purely to the outstanding limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (accept_start) begin
            stall_cycles <= '0;
        end else if (stall_hit && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_velocity_cell_ctrl.sv
// Directed bench for velocity_cell_ctrl with a 2-cycle-latency RAM model and
// a motion-update model that returns each delivered velocity XOR a mask.
module tb_velocity_cell_ctrl;

    localparam logic [95:0] UPD_MASK = 96'h0000_00FF_0000_00FF_0000_00FF;

    logic        clk, rst_n, start, busy, done;
    logic [95:0] vel_out, upd_in, host_rd_data, mem_data, mem_q;
    logic [7:0]  vel_out_addr, host_rd_addr, mem_address;
    logic        vel_out_valid, upd_valid, upd_ready;
    logic        host_rd_req, host_rd_gnt, host_rd_valid, mem_rden, mem_wren;
`ifdef VEL_CTRL_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    velocity_cell_ctrl #(
        .DATA_WIDTH      (96),
        .ADDR_WIDTH      (8),
        .PARTICLE_NUM    (220),
        .RD_LATENCY      (2),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .vel_out       (vel_out),
        .vel_out_addr  (vel_out_addr),
        .vel_out_valid (vel_out_valid),
        .upd_in        (upd_in),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .host_rd_req   (host_rd_req),
        .host_rd_addr  (host_rd_addr),
        .host_rd_gnt   (host_rd_gnt),
        .host_rd_data  (host_rd_data),
        .host_rd_valid (host_rd_valid),
        .mem_address   (mem_address),
        .mem_data      (mem_data),
        .mem_rden      (mem_rden),
        .mem_wren      (mem_wren),
        .mem_q         (mem_q)
`ifdef VEL_CTRL_STALL_CNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [95:0] pat(input int a);
        logic [31:0] x;
        x = a;
        return {32'hC0DE_0000 | x, 32'hB0B0_0000 | x, 32'hA0A0_0000 | x};
    endfunction

    // RAM model with backdoor load for test setup.
    logic        bd_init, bd_wr;
    logic [7:0]  bd_addr;
    logic [95:0] bd_data;
    logic [95:0] ram [0:255];
    logic [95:0] q1;

    always @(posedge clk) begin
        if (bd_init) for (int a = 0; a < 256; a++) ram[a] <= pat(a);
        if (bd_wr) ram[bd_addr] <= bd_data;
        if (mem_wren) ram[mem_address] <= mem_data;
        if (mem_rden) q1 <= ram[mem_address];
        mem_q <= q1;
    end

    // Event logs, cleared by the bench when it launches a pass.
    logic        clr_logs;
    int          rd_cnt, vel_cnt, wr_cnt, done_cnt, hv_cnt, both_cnt;
    logic [7:0]  vel_addr_log [0:255];
    logic [95:0] vel_data_log [0:255];
    logic [7:0]  wr_addr_log  [0:255];
    logic [95:0] wr_data_log  [0:255];
    logic [95:0] vel_by_addr  [0:255];
    logic [8:0]  exp_wr;

    always @(negedge clk) begin
        if (clr_logs) begin
            rd_cnt = 0; vel_cnt = 0; wr_cnt = 0; done_cnt = 0; hv_cnt = 0; both_cnt = 0;
        end else begin
            if (mem_rden && mem_wren) both_cnt++;
            if (mem_rden && !host_rd_gnt && mem_address != 8'd0) rd_cnt++;
            if (vel_out_valid) begin
                vel_addr_log[vel_cnt & 255] = vel_out_addr;
                vel_data_log[vel_cnt & 255] = vel_out;
                vel_by_addr[vel_out_addr]   = vel_out;
                vel_cnt++;
            end
            if (mem_wren) begin
                wr_addr_log[wr_cnt & 255] = mem_address;
                wr_data_log[wr_cnt & 255] = mem_data;
                wr_cnt++;
            end
            if (done) done_cnt++;
            if (host_rd_valid) hv_cnt++;
        end
    end

    // Motion-update model: returns particles in issue order.
    always @(posedge clk) begin
        if (clr_logs) exp_wr <= 9'd1;
        else if (upd_valid && upd_ready) exp_wr <= exp_wr + 9'd1;
    end
    assign upd_in = vel_by_addr[exp_wr[7:0]] ^ UPD_MASK;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_count(input logic [95:0] w);
        bd_init = 1'b1; bd_wr = 1'b1; bd_addr = 8'd0; bd_data = w;
        step();
        bd_init = 1'b0; bd_wr = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; clr_logs = 1'b1;
        step();
        start = 1'b0; clr_logs = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int lat);
        lat = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_pass(input string tg, input int n);
        check({tg, "_vel_cnt"}, vel_cnt, n);
        check({tg, "_rd_cnt"}, rd_cnt, n);
        check({tg, "_wr_cnt"}, wr_cnt, n);
        check({tg, "_done_cnt"}, done_cnt, 1);
        check({tg, "_rd_wr_overlap"}, both_cnt, 0);
        check({tg, "_busy_after"}, busy, 1'b0);
        for (int i = 0; i < n && i < 256; i++) begin
            check({tg, "_vel_addr"}, vel_addr_log[i], i + 1);
            check({tg, "_vel_data"}, vel_data_log[i], pat(i + 1));
            check({tg, "_wr_addr"}, wr_addr_log[i], i + 1);
            check({tg, "_wr_data"}, wr_data_log[i], pat(i + 1) ^ UPD_MASK);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        rst_n = 1'b0; start = 1'b0; upd_valid = 1'b0; host_rd_req = 1'b0;
        host_rd_addr = '0; bd_init = 1'b0; bd_wr = 1'b0; bd_addr = '0; bd_data = '0;
        clr_logs = 1'b0;

        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_vel_valid", vel_out_valid, 1'b0);
        check("rst_upd_ready", upd_ready, 1'b0);
        check("rst_host_gnt", host_rd_gnt, 1'b0);
        check("rst_host_valid", host_rd_valid, 1'b0);
        check("rst_rden", mem_rden, 1'b0);
        check("rst_wren", mem_wren, 1'b0);
        check("rst_addr", mem_address, 8'd0);

        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        set_count(96'd3);

        // Host read of address 7 while idle.
        host_rd_req = 1'b1; host_rd_addr = 8'd7;
        @(negedge clk);
        check("host_gnt", host_rd_gnt, 1'b1);
        check("host_rden", mem_rden, 1'b1);
        check("host_addr", mem_address, 8'd7);
        step();
        host_rd_req = 1'b0;
        @(negedge clk);
        check("host_valid_early", host_rd_valid, 1'b0);
        step();
        @(negedge clk);
        check("host_valid", host_rd_valid, 1'b1);
        check("host_data", host_rd_data, pat(7));
        step();

        // start and host request together: start wins; N=3 pass.
        start = 1'b1; clr_logs = 1'b1; host_rd_req = 1'b1; host_rd_addr = 8'd9; upd_valid = 1'b1;
        @(negedge clk);
        check("both_gnt", host_rd_gnt, 1'b0);
        check("both_busy_pre", busy, 1'b0);
        step();
        start = 1'b0; clr_logs = 1'b0;
        @(negedge clk);
        check("both_busy", busy, 1'b1);
        check("busy_gnt", host_rd_gnt, 1'b0);
        step();
        host_rd_req = 1'b0;
        wait_done(100, lat);
        check("n3_done_seen", lat != 0, 1'b1);
        step(); step();
        @(negedge clk);
        check("n3_no_host_valid", hv_cnt, 0);
        check_pass("n3", 3);
        step();

        // Empty cell.
        set_count(96'd0);
        upd_valid = 1'b0;
        do_start();
        wait_done(50, lat);
        check("n0_done_lat", lat, 5);
        step(); step();
        @(negedge clk);
        check("n0_vel_cnt", vel_cnt, 0);
        check("n0_wr_cnt", wr_cnt, 0);
        check("n0_done_cnt", done_cnt, 1);
        step();

        // N=20 with no returns: reads stop at the outstanding limit.
        set_count(96'd20);
        upd_valid = 1'b0;
        do_start();
        repeat (18) step();
        start = 1'b1; host_rd_req = 1'b1; host_rd_addr = 8'd5;
        @(negedge clk);
        check("stall_host_gnt", host_rd_gnt, 1'b0);
        step();
        start = 1'b0; host_rd_req = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("stall_rd_cnt", rd_cnt, 8);
        check("stall_vel_cnt", vel_cnt, 8);
        check("stall_wr_cnt", wr_cnt, 0);
        step();
        upd_valid = 1'b1;
        wait_done(400, lat);
        check("n20_done_seen", lat != 0, 1'b1);
        step(); step();
        @(negedge clk);
        check_pass("n20", 20);
`ifdef VEL_CTRL_STALL_CNT_EN
        check("n20_stall_cycles", stall_cycles, 16'd12);
`endif
        step();

        // Reset in the middle of STREAM after three reads.
        set_count(96'd5);
        upd_valid = 1'b1;
        do_start();
        repeat (7) step();
        check("mid_rd_cnt", rd_cnt, 3);
        check("mid_wren_pre", mem_wren, 1'b1);
        host_rd_req = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_wren", mem_wren, 1'b0);
        check("mid_rden", mem_rden, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_upd_ready", upd_ready, 1'b0);
        check("mid_vel_valid", vel_out_valid, 1'b0);
        check("mid_vel_out", vel_out, 96'd0);
        check("mid_host_gnt", host_rd_gnt, 1'b0);
        check("mid_addr", mem_address, 8'd0);
        check("mid_data", mem_data, 96'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1; host_rd_req = 1'b0;
        step();
        set_count(96'd5);
        do_start();
        wait_done(100, lat);
        check("rerun_done_seen", lat != 0, 1'b1);
        step(); step();
        @(negedge clk);
        check_pass("rerun", 5);
        step();

        // Oversized count clamps to the last particle address.
        set_count(96'd300);
        upd_valid = 1'b1;
        do_start();
        wait_done(2000, lat);
        check("clamp_done_seen", lat != 0, 1'b1);
        step(); step();
        @(negedge clk);
        check_pass("clamp", 219);
        check("clamp_last_wr", wr_addr_log[218], 8'd219);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
